// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the LED-cube UART frame loader: framing constants,
// FSM state encoding and the running checksum helper.
package uart_frame_loader_pkg;

    localparam logic [7:0] HEADER      = 8'hF2;
    localparam int         FRAME_BYTES = 64;
    localparam int         IDX_W       = 6;
    localparam int         DEF_TIMEOUT = 100000;
    localparam int         DEF_TMR_W   = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Running XOR checksum over the payload bytes.
    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_loader_frame_timer.sv
// Inter-byte idle timer. Counts while a frame is in progress, clears on every
// received byte and is held at zero whenever it is not running.
module uart_frame_loader_frame_timer #(
    parameter int TIMEOUT = 100000,
    parameter int TMR_W   = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    logic [TMR_W-1:0] timer_r;

    // Idle counter: zero on reset, on a byte, or outside a frame; otherwise count up.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (clear || !run) begin
            timer_r <= {TMR_W{1'b0}};
        end else begin
            timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end
    end

    // Expiry is flagged on the last allowed idle cycle; the caller gives a byte priority.
    assign expire = run && (timer_r == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame loader for the LED cube. Frames HEADER + 64 payload bytes + XOR
// checksum into the back half of a double-buffered frame RAM and swaps the
// displayed buffer only when the checksum matches.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMR_W   = DEF_TMR_W
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic             rx_en,
    output logic             wr_en,
    output logic [IDX_W:0]   wr_addr,
    output logic [7:0]       wr_data,
    output logic             disp_buf,
    output logic             frame_done,
    output logic             frame_err
);

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       chk_r;
    logic             run_s;
    logic             expire_s;

    // The timer only runs while a frame is being received or awaits its checksum.
    assign run_s = (state_r == ST_LOAD) || (state_r == ST_CHECK);

    uart_frame_loader_frame_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .clk    (clk_100M),
        .rst    (rst),
        .clear  (byte_valid),
        .run    (run_s),
        .expire (expire_s)
    );

    // Framing FSM with registered write port, buffer select and status pulses.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            chk_r      <= 8'h00;
            rx_en      <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= {(IDX_W+1){1'b0}};
            wr_data    <= 8'h00;
            disp_buf   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_en      <= 1'b1;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (byte_valid && (byte_in == HEADER)) begin
                        state_r <= ST_LOAD;
                        idx_r   <= {IDX_W{1'b0}};
                        chk_r   <= 8'h00;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (byte_valid) begin
                        // A HEADER value here is ordinary payload.
                        wr_en   <= 1'b1;
                        wr_addr <= {~disp_buf, idx_r};
                        wr_data <= byte_in;
                        chk_r   <= chk_update(chk_r, byte_in);
                        idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        if (idx_r == IDX_W'(FRAME_BYTES - 1)) begin
                            state_r <= ST_CHECK;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else if (expire_s) begin
                        frame_err <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (byte_valid) begin
                        if (byte_in == chk_r) begin
                            disp_buf   <= ~disp_buf;
                            frame_done <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else if (expire_s) begin
                        frame_err <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed self-checking bench for uart_frame_loader (short timeout for sim time).
module tb_uart_frame_loader;

    localparam int TO  = 200;
    localparam int GAP = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       rx_en;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       disp_buf;
    logic       frame_done;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    logic       exp_disp;
    logic [7:0] data [64];
    logic       saw_err;

    always #5 clk = ~clk;

    uart_frame_loader #(
        .TIMEOUT (TO),
        .TMR_W   (8)
    ) dut (
        .clk_100M   (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .rx_en      (rx_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .disp_buf   (disp_buf),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One strobe; check the pulse outputs one cycle later, then that they drop.
    task automatic send(input logic [7:0] b, input logic ew, input logic ed, input logic ee,
                        input logic [6:0] ea, input string tag);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        check({29'd0, wr_en, frame_done, frame_err}, {29'd0, ew, ed, ee}, {tag, "_pulse"});
        if (ew) check({17'd0, wr_addr, wr_data}, {17'd0, ea, b}, {tag, "_wr"});
        @(posedge clk);
        #1;
        check({29'd0, wr_en, frame_done, frame_err}, 32'd0, {tag, "_quiet"});
        repeat (GAP - 2) @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input int from, input int to, input string tag);
        for (int i = from; i < to; i++) begin
            send(data[i], 1'b1, 1'b0, 1'b0, {~exp_disp, i[5:0]}, tag);
        end
    endtask

    task automatic finish_frame(input logic [7:0] c, input logic good, input string tag);
        send(c, 1'b0, good, ~good, 7'd0, tag);
        if (good) exp_disp = ~exp_disp;
        check({31'd0, disp_buf}, {31'd0, exp_disp}, {tag, "_disp"});
    endtask

    function automatic logic [7:0] frame_xor();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 64; i++) x = x ^ data[i];
        return x;
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) data[i] = i[7:0];
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        exp_disp   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({11'd0, rx_en, wr_en, frame_done, frame_err, disp_buf, wr_addr, wr_data},
              {11'd0, 1'b1, 4'b0000, 7'd0, 8'd0}, "reset_state");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 1: ramp frame into buffer 1 (addr 64..127), checksum 0x00
        fill_ramp();
        check({24'd0, frame_xor()}, 32'h00, "t1_ramp_xor");
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t1_hdr");
        load_bytes(0, 64, "t1_data");
        finish_frame(8'h00, 1'b1, "t1_chk");

        // 2: all-0xFF frame into buffer 0
        for (int i = 0; i < 64; i++) data[i] = 8'hFF;
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t2_hdr");
        load_bytes(0, 64, "t2_data");
        finish_frame(8'h00, 1'b1, "t2_chk");

        // 3: bad checksum, then a good frame
        fill_ramp();
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t3_hdr");
        load_bytes(0, 64, "t3_data");
        finish_frame(8'h55, 1'b0, "t3_badchk");
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t3_hdr2");
        load_bytes(0, 64, "t3_data2");
        finish_frame(frame_xor(), 1'b1, "t3_goodchk");

        // 4a: timeout after 10 bytes; last strobe edge t, now past edge t+GAP-1
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t4_hdr");
        load_bytes(0, 10, "t4_data");
        repeat (TO - GAP) @(posedge clk);
        #1;
        check({31'd0, frame_err}, 32'd0, "t4_before_expiry");
        @(posedge clk);
        #1;
        check({31'd0, frame_err}, 32'd1, "t4_expiry_err");
        @(posedge clk);
        #1;
        check({30'd0, frame_err, disp_buf}, {30'd0, 1'b0, exp_disp}, "t4_err_single");
        send(8'h00, 1'b0, 1'b0, 1'b0, 7'd0, "t4_idle_after");

        // 4b: strobe exactly on the expiry cycle wins; frame completes
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t4b_hdr");
        load_bytes(0, 10, "t4b_data");
        repeat (TO - GAP) @(posedge clk);
        send(data[10], 1'b1, 1'b0, 1'b0, {~exp_disp, 6'd10}, "t4b_on_expiry");
        load_bytes(11, 64, "t4b_rest");
        finish_frame(frame_xor(), 1'b1, "t4b_chk");

        // 5: noise while idle, then payload containing the header value
        send(8'h11, 1'b0, 1'b0, 1'b0, 7'd0, "t5_noise11");
        send(8'h7E, 1'b0, 1'b0, 1'b0, 7'd0, "t5_noise7e");
        send(8'h00, 1'b0, 1'b0, 1'b0, 7'd0, "t5_noise00");
        fill_ramp();
        data[5]  = 8'hF2;
        data[40] = 8'hF2;
        check({24'd0, frame_xor()}, 32'h2D, "t5_model_xor");
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t5_hdr");
        load_bytes(0, 64, "t5_data");
        finish_frame(8'h2D, 1'b1, "t5_chk");

        // 6: reset mid-LOAD after 30 bytes, then a clean frame
        fill_ramp();
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t6_hdr");
        load_bytes(0, 30, "t6_data");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check({11'd0, rx_en, wr_en, frame_done, frame_err, disp_buf, wr_addr, wr_data},
              {11'd0, 1'b1, 4'b0000, 7'd0, 8'd0}, "t6_reset_outputs");
        @(negedge clk);
        rst      = 1'b0;
        exp_disp = 1'b0;
        saw_err  = 1'b0;
        repeat (TO + GAP) begin
            @(posedge clk);
            #1;
            saw_err = saw_err | frame_err | frame_done | wr_en;
        end
        check({31'd0, saw_err}, 32'd0, "t6_no_err_after_reset");
        send(8'hF2, 1'b0, 1'b0, 1'b0, 7'd0, "t6_hdr2");
        load_bytes(0, 64, "t6_data2");
        finish_frame(frame_xor(), 1'b1, "t6_chk");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
